// File: rtl/cpld_arb_pkg.sv
// Shared types and helpers for the CPLD round-robin arbiter.
package cpld_arb_pkg;

  localparam int ARB_N_MAX  = 8;
  localparam int ARB_IW_MAX = $clog2(ARB_N_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  function automatic logic [ARB_N_MAX-1:0] idx2oh(input logic [ARB_IW_MAX-1:0] idx);
    logic [ARB_N_MAX-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cpld_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr_i, wrapping.
module cpld_rr_pick
  import cpld_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o,
  output logic [N-1:0]  onehot_o
);

  always_comb begin : pick
    logic [ARB_N_MAX-1:0] oh_full;
    logic [IW-1:0]        cand;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
    oh_full  = idx2oh(ARB_IW_MAX'(idx_o));
    onehot_o = found_o ? oh_full[N-1:0] : '0;
  end

endmodule

// File: rtl/cpld_rr_arbiter.sv
// Round-robin owner arbiter for a shared CPLD macro with hold timeout
// and a one-cycle break-before-make gap between owners.
//
//   state | meaning
//   IDLE  | no owner; arbitrate each edge when EN=1
//   GRANT | owner holds GNT until it drops REQ or hold limit is reached
//   GAP   | one grant-low cycle after release/timeout, then arbitrate
module cpld_rr_arbiter
  import cpld_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic                 CLK,
  input  logic                 CDN,
  input  logic                 EN,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         GNT,
  output logic                 GNTV,
  output logic [$clog2(N)-1:0] GIDX,
  output logic                 TOUT
);

  localparam int            IW       = $clog2(N);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic          tout_q, tout_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_oh;

  cpld_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i    (REQ),
    .ptr_i    (ptr_q),
    .found_o  (pick_found),
    .idx_o    (pick_idx),
    .onehot_o (pick_oh)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    tout_d  = 1'b0;
    case (state_q)
      GRANT: begin
        // Release wins over timeout, so TOUT only fires if REQ is still up.
        if (!REQ[gidx_q] || (MAX_HOLD != 0 && cnt_q == HOLD_LIM)) begin
          tout_d  = REQ[gidx_q];
          state_d = GAP;
          gnt_d   = '0;
          gidx_d  = '0;
          cnt_d   = '0;
          ptr_d   = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + IW'(1);
        end else if (cnt_q != HOLD_LIM && cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (EN && pick_found) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          gidx_d  = pick_idx;
          cnt_d   = CW'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          gidx_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      gidx_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      tout_q  <= tout_d;
    end
  end

  assign GNT  = gnt_q;
  assign GNTV = |gnt_q;
  assign GIDX = gidx_q;
  assign TOUT = tout_q;

endmodule

// File: tb/tb_cpld_rr_arbiter.sv
// Directed bench for cpld_rr_arbiter (N=4, MAX_HOLD=4) with a per-cycle
// behavioural owner model plus hand-computed literal checks.
module tb_cpld_rr_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic       CLK = 1'b0;
  logic       CDN;
  logic       EN;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic       GNTV;
  logic [1:0] GIDX;
  logic       TOUT;

  int n_chk  = 0;
  int n_pass = 0;

  cpld_rr_arbiter #(.N(N), .MAX_HOLD(MAXH), .CW(5)) dut (
    .CLK  (CLK),
    .CDN  (CDN),
    .EN   (EN),
    .REQ  (REQ),
    .GNT  (GNT),
    .GNTV (GNTV),
    .GIDX (GIDX),
    .TOUT (TOUT)
  );

  always #5 CLK = ~CLK;

  // Model: who owns the resource, for how long, and where the scan starts.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_tout  = 1'b0;

  always @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_tout  = 1'b0;
    end else begin
      m_tout = 1'b0;
      if (m_owner >= 0) begin
        if (!REQ[m_owner]) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end else if (m_held == MAXH) begin
          m_tout  = 1'b1;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end else begin
          m_held = m_held + 1;
        end
      end else if (EN && REQ != 4'b0000) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && REQ[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        m_held = 1;
      end
    end
  end

  always @(negedge CLK) begin
    logic [3:0] eg;
    logic [1:0] ei;
    if (CDN) begin
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      ei = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      n_chk++;
      if ({GNT, GNTV, GIDX, TOUT} === {eg, |eg, ei, m_tout}) n_pass++;
      else $display("FAIL model t=%0t: got gnt=%b v=%b idx=%0d tout=%b, want gnt=%b v=%b idx=%0d tout=%b",
                    $time, GNT, GNTV, GIDX, TOUT, eg, |eg, ei, m_tout);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t: got %0h want %0h", name, $time, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    CDN = 1'b0;
    EN  = 1'b1;
    REQ = 4'b0000;
    #3;
    chk("rst_gnt", 32'(GNT), 32'h0);
    chk("rst_misc", 32'({GNTV, GIDX, TOUT}), 32'h0);
    @(negedge CLK);
    CDN = 1'b1;

    // Rotation: each owner holds 3 cycles, drops, reasserts during the gap.
    REQ = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      tick(1);
      chk("rot_own", 32'(GNT), 32'(1 << (o % 4)));
      chk("rot_idx", 32'(GIDX), 32'(o % 4));
      tick(2);
      chk("rot_hold", 32'(GNT), 32'(1 << (o % 4)));
      REQ[o % 4] = 1'b0;
      tick(1);
      chk("rot_gap", 32'(GNT), 32'h0);
      REQ[o % 4] = 1'b1;
    end
    REQ = 4'b0000;
    tick(2);

    // Timeout: lone requester held 4 cycles, 1-cycle gap with TOUT, repeat.
    REQ = 4'b0001;
    tick(1);
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 4; i++) begin
        chk("to_hold", 32'({GNT, TOUT}), 32'({4'b0001, 1'b0}));
        tick(1);
      end
      chk("to_pulse", 32'({GNT, TOUT}), 32'({4'b0000, 1'b1}));
      tick(1);
    end
    chk("to_regrant", 32'(GNT), 32'h1);
    REQ = 4'b0000;
    tick(2);

    // Release on the timeout edge: no TOUT, pointer moves to 3.
    REQ = 4'b0100;
    tick(1);
    chk("sim_own", 32'(GNT), 32'h4);
    tick(3);
    REQ = 4'b0000;
    tick(1);
    chk("sim_rel", 32'({GNT, TOUT}), 32'h0);
    REQ = 4'b1111;
    tick(1);
    chk("sim_ptr3", 32'(GNT), 32'h8);

    // Pointer wrap: owner 3 releases, 0 wins, 3 waits for 0.
    REQ = 4'b0001;
    tick(1);
    chk("wrap_gap", 32'(GNT), 32'h0);
    REQ = 4'b1001;
    tick(1);
    chk("wrap_pick0", 32'(GNT), 32'h1);
    tick(2);
    chk("wrap_wait3", 32'(GNT), 32'h1);
    REQ = 4'b1000;
    tick(1);
    chk("wrap_gap2", 32'(GNT), 32'h0);
    tick(1);
    chk("wrap_serve3", 32'({GNT, GIDX}), 32'({4'b1000, 2'd3}));
    REQ = 4'b0000;
    tick(2);

    // Enable gating.
    EN  = 1'b0;
    REQ = 4'b1000;
    tick(3);
    chk("en_block", 32'(GNT), 32'h0);
    EN = 1'b1;
    tick(1);
    chk("en_grant", 32'(GNT), 32'h8);
    EN = 1'b0;
    tick(2);
    chk("en_persist", 32'(GNT), 32'h8);
    REQ = 4'b0000;
    tick(1);
    chk("en_release", 32'(GNT), 32'h0);
    EN = 1'b1;
    tick(1);

    // Asynchronous clear in the middle of a grant.
    REQ = 4'b0010;
    tick(2);
    chk("pre_rst_own", 32'(GNT), 32'h2);
    #2 CDN = 1'b0;
    #1 chk("async_clr", 32'({GNT, GNTV, GIDX, TOUT}), 32'h0);
    #1 CDN = 1'b1;
    @(negedge CLK);
    chk("post_rst_own", 32'({GNT, GIDX}), 32'({4'b0010, 2'd1}));
    REQ = 4'b0000;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
